// File: rtl/sram_bus_tester.sv
// ---------------------------------------------------------------------------
// sram_bus_tester
//
// Self-test initiator for the bus side of sram_controller. It writes an
// address-derived pattern over [base_addr, last_addr], reads the range back,
// compares each word and reports pass/fail, a saturating error count and the
// address of the first mismatching word.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (accepted only while idle)
//   base_addr         first word address, latched on accepted start
//   last_addr         last word address (inclusive), latched on accepted start
//   busy              run in progress
//   done              one-cycle pulse at the end of a run
//   pass              result of the last run, held until the next start
//   err_count         mismatching words, saturating at all-ones
//   first_err_addr    address of the first mismatch, 0 if none
//   bus_addr          address to sram_controller
//   read_op/write_op  access strobes to sram_controller (never both high)
//   bus_data_write    write data, 0 whenever write_op is low
//   byte_mask         always 4'b1111 (full-word accesses)
//   bus_data_read     read data from sram_controller
// ---------------------------------------------------------------------------
package sram_bus_tester_pkg;
  typedef logic [19:0] ram_addr_t;
  typedef logic [31:0] word_t;
endpackage

module sram_bus_tester
  import sram_bus_tester_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'h5A5A_0000,
  parameter int          ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  ram_addr_t        base_addr,
  input  ram_addr_t        last_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output ram_addr_t        first_err_addr,
  output ram_addr_t        bus_addr,
  output logic             read_op,
  output logic             write_op,
  output word_t            bus_data_write,
  output logic [3:0]       byte_mask,
  input  word_t            bus_data_read
);

  // Counts op cycles 0 .. ACCESS_CYCLES-1 within one access.
  localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_OP,
    WR_GAP,
    RD_OP,
    RD_GAP,
    FIN
  } state_t;

  state_t           state;
  ram_addr_t        base_q;
  ram_addr_t        last_q;
  ram_addr_t        cur;
  logic [CNT_W-1:0] cnt;

  // Address-derived test word: the address appears twice so that both the
  // high and low data lanes see address-dependent bits.
  function automatic word_t pattern(input ram_addr_t a);
    return SEED ^ {a, a[11:0]};
  endfunction

  assign byte_mask = 4'b1111;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // mixing in blocking writes would make later statements in this block see
  // next-cycle values and create simulation/synthesis mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      base_q         <= '0;
      last_q         <= '0;
      cur            <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      bus_addr       <= '0;
      read_op        <= 1'b0;
      write_op       <= 1'b0;
      bus_data_write <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            last_q         <= last_addr;
            cur            <= base_addr;
            cnt            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            if (last_addr < base_addr) begin
              // Empty range: nothing to test, report a clean run next cycle.
              state <= FIN;
            end else begin
              state          <= WR_OP;
              write_op       <= 1'b1;
              bus_addr       <= base_addr;
              bus_data_write <= pattern(base_addr);
            end
          end
        end

        WR_OP: begin
          if (cnt == CNT_LAST) begin
            state          <= WR_GAP;
            write_op       <= 1'b0;
            bus_data_write <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WR_GAP: begin
          cnt <= '0;
          // Compare before incrementing so last = 20'hFFFFF ends cleanly
          // instead of wrapping to address 0.
          if (cur == last_q) begin
            state    <= RD_OP;
            cur      <= base_q;
            read_op  <= 1'b1;
            bus_addr <= base_q;
          end else begin
            state          <= WR_OP;
            cur            <= cur + 20'd1;
            write_op       <= 1'b1;
            bus_addr       <= cur + 20'd1;
            bus_data_write <= pattern(cur + 20'd1);
          end
        end

        RD_OP: begin
          if (cnt == CNT_LAST) begin
            // Read data is valid at the edge that ends the last op cycle.
            state   <= RD_GAP;
            read_op <= 1'b0;
            if (bus_data_read != pattern(cur)) begin
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
              // err_count never returns to zero once it has counted, so a
              // zero count means this is the first mismatch of the run.
              if (err_count == '0) begin
                first_err_addr <= cur;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RD_GAP: begin
          cnt <= '0;
          if (cur == last_q) begin
            state <= FIN;
          end else begin
            state    <= RD_OP;
            cur      <= cur + 20'd1;
            read_op  <= 1'b1;
            bus_addr <= cur + 20'd1;
          end
        end

        FIN: begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_tester.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_tester
//
// Scoreboard bench for sram_bus_tester. The bench plays the memory behind
// sram_controller with an associative array, optionally corrupting chosen
// words between the write and read phases. For every started run the
// stimulus queues the expected bus accesses and the expected result; a
// monitor running on the falling edge pops and compares them as the DUT
// produces accesses and done pulses.
// ---------------------------------------------------------------------------
module tb_sram_bus_tester;
  import sram_bus_tester_pkg::*;

  localparam int          AC   = 2;
  localparam int          EW   = 2;
  localparam logic [31:0] SEED = 32'h5A5A_0000;
  localparam int          EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  ram_addr_t     base_addr;
  ram_addr_t     last_addr;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_count;
  ram_addr_t     first_err_addr;
  ram_addr_t     bus_addr;
  logic          read_op;
  logic          write_op;
  word_t         bus_data_write;
  logic [3:0]    byte_mask;
  word_t         bus_data_read = '0;

  sram_bus_tester #(
    .ACCESS_CYCLES(AC),
    .SEED         (SEED),
    .ERR_W        (EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .last_addr     (last_addr),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .bus_addr      (bus_addr),
    .read_op       (read_op),
    .write_op      (write_op),
    .bus_data_write(bus_data_write),
    .byte_mask     (byte_mask),
    .bus_data_read (bus_data_read)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            done_cyc;
    logic [EW-1:0] err;
    ram_addr_t     first;
    logic          pass;
  } exp_t;

  typedef struct {
    logic      wr;
    ram_addr_t addr;
  } op_t;

  exp_t  sb_q[$];
  op_t   op_q[$];
  word_t mem[ram_addr_t];
  word_t flip[ram_addr_t];
  bit    flipped = 1'b0;

  int n_tests   = 0;
  int n_fail    = 0;
  int runs_done = 0;
  int runs_exp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic word_t pat(input ram_addr_t a);
    return SEED ^ {a, a[11:0]};
  endfunction

  // ---------------- monitor / memory model ----------------
  bit        in_op     = 1'b0;
  bit        prev_done = 1'b0;
  int        op_len    = 0;
  logic      op_wr;
  ram_addr_t op_addr;
  word_t     op_data;
  op_t       oe;
  exp_t      ee;

  always @(negedge clk) begin
    if (rst) begin
      in_op         = 1'b0;
      op_len        = 0;
      prev_done     = 1'b0;
      bus_data_read = '0;
    end else begin
      check("ops_exclusive", read_op & write_op, 0);
      if (!write_op) check("wdata_idle_zero", bus_data_write, 0);

      if (read_op || write_op) begin
        if (!in_op) begin
          // First read of a run: corrupt the chosen words, as if the
          // memory was disturbed between the phases.
          if (read_op && !flipped) begin
            foreach (flip[a]) if (mem.exists(a)) mem[a] = mem[a] ^ flip[a];
            flipped = 1'b1;
          end
          if (op_q.size() == 0) begin
            check("unexpected_op", 1, 0);
          end else begin
            oe = op_q.pop_front();
            check("op_kind", write_op, oe.wr);
            check("op_addr", bus_addr, oe.addr);
          end
          if (write_op) begin
            check("wdata", bus_data_write, pat(bus_addr));
            mem[bus_addr] = bus_data_write;
          end
          in_op   = 1'b1;
          op_len  = 1;
          op_wr   = write_op;
          op_addr = bus_addr;
          op_data = bus_data_write;
        end else begin
          op_len++;
          check("op_hold", {op_wr, op_addr, op_data}, {write_op, bus_addr, bus_data_write});
        end
      end else if (in_op) begin
        check("op_len", op_len, AC);
        in_op = 1'b0;
      end

      bus_data_read = (read_op && mem.exists(bus_addr)) ? mem[bus_addr] : '0;

      if (done) begin
        check("done_pulse", prev_done, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          ee = sb_q.pop_front();
          check("done_cycle", cyc, ee.done_cyc);
          check("err_count", err_count, ee.err);
          check("first_err_addr", first_err_addr, ee.first);
          check("pass", pass, ee.pass);
          check("busy_at_done", busy, 0);
        end
        runs_done++;
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+2ns; returns at posedge+2ns after the accepting edge.
  // Caller fills flip[] with in-range corruptions beforehand.
  task automatic run(input ram_addr_t b, input ram_addr_t l, input bit hold);
    int        n;
    int        nerr;
    ram_addr_t first;
    exp_t      e;
    n       = (l < b) ? 0 : int'(l - b) + 1;
    nerr    = flip.num();
    first   = '0;
    if (nerr > 0) void'(flip.first(first));
    flipped = 1'b0;
    for (int i = 0; i < n; i++) op_q.push_back('{wr: 1'b1, addr: b + ram_addr_t'(i)});
    for (int i = 0; i < n; i++) op_q.push_back('{wr: 1'b0, addr: b + ram_addr_t'(i)});
    e.err  = (nerr > EMAX) ? EW'(EMAX) : EW'(nerr);
    e.first = first;
    e.pass  = (nerr == 0);
    base_addr = b;
    last_addr = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.done_cyc = cyc + ((n == 0) ? 1 : 2 * n * (AC + 1) + 1);
    sb_q.push_back(e);
    runs_exp++;
    check("busy_after_start", busy, 1);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_runs(input int budget);
    for (int i = 0; i < budget && runs_done < runs_exp; i++) @(posedge clk);
    check("run_completes", runs_done >= runs_exp, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err_addr, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_read_op", read_op, 0);
    check("rst_write_op", write_op, 0);
    check("rst_wdata", bus_data_write, 0);
  endtask

  initial begin
    ram_addr_t b;
    ram_addr_t l;
    int        len;
    int        nf;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    last_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    check("byte_mask", byte_mask, 4'hF);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // Clean 4-word run.
    flip.delete();
    run(20'h00010, 20'h00013, 1'b0);
    wait_runs(60);
    check("first_word_stored", mem[20'h00010], 32'h5A5B_0010);

    // Bit 3 of word 0x00012 disturbed between the phases.
    flip.delete();
    flip[20'h00012] = 32'h0000_0008;
    run(20'h00010, 20'h00013, 1'b0);
    wait_runs(60);

    // Empty range: no access may appear (monitor flags any op).
    flip.delete();
    run(20'h00020, 20'h0001F, 1'b0);
    wait_runs(20);

    // Five corrupted words saturate a 2-bit counter.
    flip.delete();
    for (int i = 0; i < 5; i++) flip[20'h00030 + ram_addr_t'(i)] = 32'h1 << i;
    run(20'h00030, 20'h00034, 1'b0);
    wait_runs(80);

    // Reset during the third write, then a fresh run.
    flip.delete();
    run(20'h00040, 20'h00047, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    check("in_third_write", {write_op, bus_addr}, {1'b1, 20'h00042});
    #1;
    rst = 1'b1;
    sb_q.delete();
    op_q.delete();
    runs_exp--;
    @(posedge clk);
    #1;
    check_reset_values();
    @(posedge clk);
    #2 rst = 1'b0;
    run(20'h00040, 20'h00047, 1'b0);
    wait_runs(120);

    // start held through a run with an extra pulse mid-run.
    flip.delete();
    run(20'h00050, 20'h00052, 1'b1);
    repeat (5) @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2 start = 1'b1;
    repeat (2 * 3 * (AC + 1) + 1 - 6) @(posedge clk);
    #2 start = 1'b0;
    wait_runs(40);
    repeat (20) @(posedge clk);
    #1;
    check("single_run_per_start", runs_done, runs_exp);
    check("pass_held", pass, 1);
    #1;

    // Randomised runs, including empty ranges and the top of the space.
    for (int r = 0; r < 8; r++) begin
      flip.delete();
      b   = ram_addr_t'($urandom());
      len = $urandom_range(0, 6);
      if (r == 7) begin
        b   = 20'hFFFFB;
        len = 5;
      end
      if (b > 20'hFFFF9 && r != 7) b = 20'hFFFF9;
      if (len == 0) begin
        if (b == '0) b = 20'd1;
        l = b - 20'd1;
      end else begin
        l  = b + ram_addr_t'(len - 1);
        nf = $urandom_range(0, 3);
        for (int k = 0; k < nf; k++)
          flip[b + ram_addr_t'($urandom_range(0, len - 1))] = 32'h1 << $urandom_range(0, 31);
      end
      run(b, l, 1'b0);
      wait_runs(120);
    end

    check("queues_drained", sb_q.size() + op_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_tester.md
Name: sram_bus_tester

Overview:
- Synthesizable self-test initiator that drives the bus side of sram_controller: bus_addr, read_op, write_op, bus_data_write and byte_mask, and samples bus_data_read.
- It writes a deterministic address-derived pattern over a programmable word range, reads the range back and compares each word.
- It reports pass/fail, a saturating error count and the first failing address.
- Used in board bring-up and in the peripheral testbench, connected in place of the CPU memory port ahead of sram_controller + fake_sram.

Parameters:
- ACCESS_CYCLES, 2: cycles read_op/write_op is held per access; min 1.
- SEED, 32'h5A5A_0000: XOR seed for the data pattern.
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a test run; sampled only in IDLE
- base_addr  input  Ram_addr_t (20)  first word address; latched on accepted start
- last_addr  input  Ram_addr_t (20)  last word address, inclusive; latched on accepted start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at end of run
- pass  output  1  result of the last run; held until the next accepted start
- err_count  output  ERR_W  mismatching words, saturating at all-ones
- first_err_addr  output  Ram_addr_t  address of the first mismatch; 0 if none
- bus_addr  output  Ram_addr_t  to sram_controller
- read_op  output  Bit_t  to sram_controller
- write_op  output  Bit_t  to sram_controller
- bus_data_write  output  Word_t  to sram_controller
- byte_mask  output  4  constant 4'b1111
- bus_data_read  input  Word_t  from sram_controller

Behaviour:
- Reset values (on any rst edge, including mid-run):
  - state=IDLE, busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
  - bus_addr=0, read_op=0, write_op=0, bus_data_write=0.
  - Ops deassert at the reset edge; an in-flight access is abandoned.
- Pattern: P(a) = SEED ^ {a[19:0], a[11:0]} (32 bits).
- States: IDLE -> WR_OP -> WR_GAP -> (WR_OP | RD_OP) ; RD_OP -> RD_GAP -> (RD_OP | FIN) ; FIN -> IDLE.
- IDLE:
  - start=1 latches base/last and clears err_count, first_err_addr and pass.
  - If last_addr < base_addr (empty range), go to FIN directly; the result is pass=1, err_count=0.
  - Otherwise load cur=base and go to WR_OP. start in any other state is ignored.
- WR_OP: write_op=1, bus_addr=cur, bus_data_write=P(cur), all held constant for exactly ACCESS_CYCLES cycles, then WR_GAP.
- WR_GAP: 1 cycle, all ops 0.
  - If cur==last: cur<=base, go to RD_OP.
  - Else cur<=cur+1, go to WR_OP.
- RD_OP: read_op=1, bus_addr=cur for ACCESS_CYCLES cycles.
  - bus_data_read is sampled at the clock edge ending the last op cycle and compared to P(cur).
  - On mismatch: err_count increments (no wrap past all-ones). If this is the first mismatch of the run, first_err_addr<=cur.
- RD_GAP: 1 cycle, ops 0.
  - If cur==last, go to FIN.
  - Else cur<=cur+1, go to RD_OP.
- FIN: done=1 for this one cycle; pass=(no mismatch in run), held afterwards; busy=0.
- read_op and write_op are never both high. At least one idle cycle separates consecutive accesses.
- Address increment is 20-bit. last=20'hFFFFF terminates at the cur==last compare, with no wrap to 0.
- Latency: for N=last-base+1 words, done rises 2*N*(ACCESS_CYCLES+1)+1 cycles after the start-accepting edge. Empty range: 1 cycle.
- bus_data_write is 0 whenever write_op=0.

Test Plan:
- ACCESS_CYCLES=2, base=0x00010, last=0x00013, clean fake_sram.
  - 4 writes; first is bus_data_write=0x5A5B0010 at addr 0x00010 with write_op high 2 cycles, then a 1-cycle gap.
  - Then 4 reads.
  - done pulses 25 cycles after start; pass=1, err_count=0.
- Same range; bench flips bit 3 of word 0x00012 inside fake_sram between the phases.
  - Result: err_count=1, first_err_addr=0x00012, pass=0.
- base=0x00020, last=0x0001F (empty range): done at cycle 1, pass=1, no op ever asserted.
- ERR_W=2, 5 corrupted words at 0x00030..0x00034: err_count saturates at 3, first_err_addr=0x00030.
- rst pulsed during the 3rd write, then a new start:
  - At the reset edge all ops are 0 and every output holds its reset value.
  - The new run completes with pass=1.
- start held high through a whole run plus a second start pulse while busy:
  - Exactly one run executes per IDLE acceptance.
  - The monitor flags any cycle with read_op&write_op=1; none must occur.
